// File: rtl/fop_sequencer.sv
// Run controller for the fop core: reset pulse, bounded or free-running enable window, done/abort report.
// Optional FOP_SEQ_STEP_EN adds single-step enable gating (step_mode/step ports).
module fop_sequencer #(
  parameter int CNT_W      = 16,
  parameter int RST_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] run_cycles,
  input  logic             abort,
`ifdef FOP_SEQ_STEP_EN
  input  logic             step_mode,
  input  logic             step,
`endif
  output logic             fop_reset,
  output logic             fop_enable,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {IDLE, RST, RUN, DONE} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] run_len, run_len_d, cycle_count_d, issued;
  logic [7:0]       rst_cnt, rst_cnt_d;
  logic             fop_reset_d, fop_enable_d, busy_d, done_d, aborted_d;
  logic             reached, go;

`ifdef FOP_SEQ_STEP_EN
  logic step_mode_q, step_mode_d;
  // Enable for the next RUN cycle follows the registered step request.
  assign go = step_mode_q ? step : 1'b1;
`else
  assign go = 1'b1;
`endif

  always_comb begin
    issued        = (fop_enable && cycle_count != '1) ? cycle_count + CNT_W'(1) : cycle_count;
    reached       = (run_len != '0) && (issued == run_len);
    state_d       = state;
    run_len_d     = run_len;
    rst_cnt_d     = rst_cnt;
    cycle_count_d = cycle_count;
    aborted_d     = aborted;
    busy_d        = busy;
    fop_reset_d   = 1'b0;
    fop_enable_d  = 1'b0;
    done_d        = 1'b0;
`ifdef FOP_SEQ_STEP_EN
    step_mode_d   = step_mode_q;
`endif
    case (state)
      IDLE: begin
        busy_d = 1'b0;
        if (start && !abort) begin
          state_d       = RST;
          run_len_d     = run_cycles;
          cycle_count_d = '0;
          aborted_d     = 1'b0;
          rst_cnt_d     = '0;
          fop_reset_d   = 1'b1;
          busy_d        = 1'b1;
`ifdef FOP_SEQ_STEP_EN
          step_mode_d   = step_mode;
`endif
        end
      end
      RST: begin
        if (abort) begin
          state_d   = DONE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
          busy_d    = 1'b0;
        end else if (rst_cnt == 8'(RST_CYCLES - 1)) begin
          state_d      = RUN;
          fop_enable_d = go;
        end else begin
          rst_cnt_d   = rst_cnt + 8'd1;
          fop_reset_d = 1'b1;
        end
      end
      RUN: begin
        // The cycle just finished counts even when it is the last one.
        cycle_count_d = issued;
        if (abort) begin
          state_d   = DONE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
          busy_d    = 1'b0;
        end else if (reached) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          fop_enable_d = go;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      run_len     <= '0;
      rst_cnt     <= '0;
      cycle_count <= '0;
      aborted     <= 1'b0;
      busy        <= 1'b0;
      fop_reset   <= 1'b0;
      fop_enable  <= 1'b0;
      done        <= 1'b0;
`ifdef FOP_SEQ_STEP_EN
      step_mode_q <= 1'b0;
`endif
    end else begin
      state       <= state_d;
      run_len     <= run_len_d;
      rst_cnt     <= rst_cnt_d;
      cycle_count <= cycle_count_d;
      aborted     <= aborted_d;
      busy        <= busy_d;
      fop_reset   <= fop_reset_d;
      fop_enable  <= fop_enable_d;
      done        <= done_d;
`ifdef FOP_SEQ_STEP_EN
      step_mode_q <= step_mode_d;
`endif
    end
  end

endmodule

// File: tb/tb_fop_sequencer.sv
// Directed bench for fop_sequencer: two instances (RST_CYCLES 1 and 3) share stimulus;
// run results are queued at start and compared when done pulses.
`define CHK(tag, got, exp) begin tests++; assert ((got) === (exp)) else begin fails++; $error("FAIL %s got=%0h exp=%0h", tag, got, exp); end end

module tb_fop_sequencer;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset, start, abort;
  logic [CNT_W-1:0] run_cycles;
`ifdef FOP_SEQ_STEP_EN
  logic             step_mode, step;
`endif
  logic             a_rst, a_en, a_busy, a_done, a_ab;
  logic             b_rst, b_en, b_busy, b_done, b_ab;
  logic [CNT_W-1:0] a_cnt, b_cnt;

  typedef struct packed {logic [CNT_W-1:0] cnt; logic ab;} exp_t;
  exp_t sbq[$];
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  fop_sequencer #(.CNT_W(CNT_W), .RST_CYCLES(1)) dut_a (
    .clk(clk), .reset(reset), .start(start), .run_cycles(run_cycles), .abort(abort),
`ifdef FOP_SEQ_STEP_EN
    .step_mode(step_mode), .step(step),
`endif
    .fop_reset(a_rst), .fop_enable(a_en), .busy(a_busy), .done(a_done),
    .aborted(a_ab), .cycle_count(a_cnt));

  fop_sequencer #(.CNT_W(CNT_W), .RST_CYCLES(3)) dut_b (
    .clk(clk), .reset(reset), .start(start), .run_cycles(run_cycles), .abort(abort),
`ifdef FOP_SEQ_STEP_EN
    .step_mode(step_mode), .step(step),
`endif
    .fop_reset(b_rst), .fop_enable(b_en), .busy(b_busy), .done(b_done),
    .aborted(b_ab), .cycle_count(b_cnt));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_zero(input string tag);
    tests++;
    if ({a_rst, a_en, a_busy, a_done, a_ab} !== 5'b0 || a_cnt !== 16'd0) begin
      fails++;
      $error("FAIL %s_a ctl=%b cnt=%0h exp all zero", tag,
             {a_rst, a_en, a_busy, a_done, a_ab}, a_cnt);
    end
    tests++;
    if ({b_rst, b_en, b_busy, b_done, b_ab} !== 5'b0 || b_cnt !== 16'd0) begin
      fails++;
      $error("FAIL %s_b ctl=%b cnt=%0h exp all zero", tag,
             {b_rst, b_en, b_busy, b_done, b_ab}, b_cnt);
    end
  endtask

  task automatic sb_pop(input string tag, input logic [CNT_W-1:0] cnt, input logic ab);
    exp_t e;
    `CHK({tag, "_sbq"}, (sbq.size() != 0), 1'b1)
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      `CHK({tag, "_count"}, cnt, e.cnt)
      `CHK({tag, "_aborted"}, ab, e.ab)
    end
  endtask

  // Waits up to budget cycles for the selected instance's done pulse.
  task automatic wait_done(input bit sel_b, input string tag, input int budget);
    int n = 0;
    while (!(sel_b ? b_done : a_done) && n < budget) begin
      tick();
      n++;
    end
    tests++;
    if (!(sel_b ? b_done : a_done)) begin
      fails++;
      $error("FAIL %s_done: no done pulse within %0d cycles", tag, budget);
    end else begin
      if (sel_b) sb_pop(tag, b_cnt, b_ab);
      else       sb_pop(tag, a_cnt, a_ab);
    end
  endtask

  // RST_CYCLES=1, N=5: reset at k+1, enable k+2..k+6, done at k+7.
  task automatic run_basic(input string tag);
    run_cycles = 16'd5;
    start = 1'b1;
    sbq.push_back('{16'd5, 1'b0});
    tick();
    start = 1'b0;
    run_cycles = 16'hBEEF;
    `CHK({tag, "_rst"}, {a_rst, a_en, a_busy}, 3'b101)
    `CHK({tag, "_clr_ab"}, a_ab, 1'b0)
    `CHK({tag, "_clr_cnt"}, a_cnt, 16'd0)
    tick();
    for (int i = 0; i < 5; i++) begin
      `CHK({tag, "_run"}, {a_rst, a_en, a_busy, a_done}, 4'b0110)
      tick();
    end
    `CHK({tag, "_fin"}, {a_rst, a_en, a_busy}, 3'b000)
    wait_done(1'b0, tag, 0);
    idle(4);
  endtask

`ifdef FOP_SEQ_STEP_EN
  task automatic run_step();
    logic [7:0] pat;
    int seen = 0;
    pat = 8'b0101_0010;
    step_mode = 1'b1;
    run_cycles = 16'd3;
    start = 1'b1;
    sbq.push_back('{16'd3, 1'b0});
    tick();
    start = 1'b0;
    step_mode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step = pat[i];
      tick();
      `CHK("step_en", a_en, pat[i])
      `CHK("step_norst", a_rst, 1'b0)
      if (pat[i]) seen++;
      if (seen == 3) break;
    end
    step = 1'b0;
    tick();
    wait_done(1'b0, "step", 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    idle(3);
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; run_cycles = '0;
`ifdef FOP_SEQ_STEP_EN
    step_mode = 1'b0; step = 1'b0;
`endif
    idle(2);
    chk_zero("reset_state");
    reset = 1'b0;
    tick();

    run_basic("basic");

    // Long reset on instance b: reset k+1..k+3, enable k+4..k+5, done k+6.
    run_cycles = 16'd2;
    start = 1'b1;
    sbq.push_back('{16'd2, 1'b0});
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      `CHK("long_rst", {b_rst, b_en, b_busy}, 3'b101)
      `CHK("no_overlap_a", (a_rst && a_en), 1'b0)
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      `CHK("long_en", {b_rst, b_en, b_busy}, 3'b011)
      tick();
    end
    wait_done(1'b1, "long", 0);
    idle(3);

    // Free-run, ignored start mid-run, abort after 10 enables.
    run_cycles = 16'd0;
    start = 1'b1;
    sbq.push_back('{16'd10, 1'b1});
    tick();
    start = 1'b0;
    tick();
    for (int i = 1; i <= 9; i++) begin
      start = (i == 4);
      tick();
      `CHK("free_run", {a_rst, a_en, a_busy}, 3'b011)
      `CHK("free_cnt", a_cnt, 16'(i))
    end
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    `CHK("abort_out", {a_rst, a_en, a_busy}, 3'b000)
    wait_done(1'b0, "abort", 0);
    tick();
    `CHK("abort_hold", {a_ab, a_done}, 2'b10)
    idle(2);

    // start together with abort in IDLE is ignored.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    `CHK("start_abort_busy", {a_busy, a_rst, b_busy}, 3'b000)
    tick();
    `CHK("start_abort_keep", {a_busy, a_ab}, 2'b01)

    run_basic("after_abort");

    // Sequencer reset in the middle of a long run.
    run_cycles = 16'd100;
    start = 1'b1;
    tick();
    start = 1'b0;
    idle(3);
    `CHK("mid_run_en", a_en, 1'b1)
    reset = 1'b1;
    tick();
    chk_zero("mid_reset");
    reset = 1'b0;
    tick();
    run_basic("after_reset");

`ifdef FOP_SEQ_STEP_EN
    run_step();
`endif

    `CHK("sbq_drained", sbq.size(), 0)
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fop_sequencer.md
Name: fop_sequencer

Overview:
Hardware run controller that drives the fop core's control interface (reset, enable).
- On a start request it issues a fop reset pulse, then holds fop enable for a programmed number of cycles (or indefinitely), then reports completion.
- Sits between system/host control logic and the fop instance, replacing the hand-written reset/enable sequencing with a synthesizable block.

Parameters:
CNT_W, 16, width of run-length and cycle counters
RST_CYCLES, 1, cycles fop_reset is held high per run (legal range 1..255)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset of the sequencer
start  input  1  request a run; sampled only in IDLE
run_cycles  input  CNT_W  number of fop enable cycles; 0 = free-run until abort; captured on accepted start
abort  input  1  terminate run in progress
fop_reset  output  1  drives fop reset port
fop_enable  output  1  drives fop enable port
busy  output  1  high from cycle after accepted start until done pulse
done  output  1  one-cycle completion pulse
aborted  output  1  high with done if run ended by abort; holds until next accepted start
cycle_count  output  CNT_W  enable cycles issued in current/last run, saturating

Behaviour:
- One clock domain. Reset is synchronous and active-high: clk and reset as named above.
- All outputs registered. Reset values: fop_reset=0, fop_enable=0, busy=0, done=0, aborted=0, cycle_count=0, state=IDLE, captured run length=0.
- States: IDLE, RST, RUN, DONE.
- IDLE:
  - start=1 and abort=0 at edge k -> capture run_cycles, clear cycle_count and aborted, go to RST.
  - start with abort in the same cycle -> start is ignored; stay in IDLE.
- RST:
  - fop_reset=1 and busy=1 during cycles k+1 .. k+RST_CYCLES; fop_enable=0.
  - Then go to RUN.
- RUN:
  - fop_enable=1, fop_reset=0, busy=1.
  - cycle_count increments each enabled cycle and saturates at 2^CNT_W-1.
  - Captured N>0: enable is high exactly N cycles, k+RST_CYCLES+1 .. k+RST_CYCLES+N; then go to DONE.
  - N=0: remain in RUN until abort.
- DONE:
  - One cycle with done=1, busy=0, fop_enable=0, fop_reset=0; then IDLE.
  - Pulse at cycle k+RST_CYCLES+N+1.
- Abort in RST or RUN at edge j:
  - Cycle j+1 is DONE, with fop_enable=0, fop_reset=0, done=1, aborted=1.
  - cycle_count freezes at enables issued before j+1.
  - Abort in IDLE or DONE has no effect.
- start while busy or in DONE is ignored. No queuing.
- run_cycles changes after capture have no effect on the current run.
- Sequencer reset mid-run: next cycle all outputs return to reset values, which also deasserts fop_enable immediately.
- fop_reset and fop_enable are never high in the same cycle.

Optional Feature:
FOP_SEQ_STEP_EN
- Defined: adds input step_mode (1 bit, captured with start) and input step (1 bit).
  - With captured step_mode=1, RUN asserts fop_enable for exactly one cycle per cycle with step=1; otherwise fop_enable=0.
  - Only stepped cycles count toward N and cycle_count.
  - step held high for M cycles yields M enable cycles.
  - Abort behaves as in normal RUN.
- Undefined: the step_mode and step ports do not exist; RUN enables continuously as above.

Test Plan:
- Basic run: reset, RST_CYCLES=1, start=1 with run_cycles=5 at edge k -> fop_reset high cycle k+1; fop_enable high k+2..k+6; done/busy-fall at k+7; cycle_count=5; aborted=0.
- Long reset: RST_CYCLES=3, run_cycles=2 -> fop_reset high 3 cycles, enable 2 cycles, done 6 cycles after start edge; reset and enable never overlap.
- Free-run plus abort: run_cycles=0, abort asserted after 10 enable cycles -> next cycle fop_enable=0, done=1, aborted=1, cycle_count=10.
- Ignored requests:
  - start during RUN changes nothing.
  - start+abort together in IDLE -> busy stays 0.
  - new start after done clears aborted and cycle_count.
- Mid-run reset: reset=1 during RUN with run_cycles=100 -> following cycle all outputs 0, state IDLE; next start behaves as the basic run.
- Step (FOP_SEQ_STEP_EN): step_mode=1, run_cycles=3, three isolated step pulses -> exactly 3 single-cycle enables aligned to the step cycles; done one cycle after the third; cycle_count=3.
